// File: rtl/wb_arbiter_pkg.sv
// Shared widths and request record for the write-back arbiter slice.
package wb_arbiter_pkg;

  localparam int WB_AW    = 5;
  localparam int WB_DW    = 32;
  localparam int WB_NREGS = 2 ** WB_AW;

  // One requester's write-back request as seen by the arbiter.
  typedef struct packed {
    logic              valid;
    logic [WB_AW-1:0]  addr;
    logic [WB_DW-1:0]  data;
  } wb_req_t;

endpackage

// File: rtl/wb_arbiter_if.sv
// Write-back request bus between the pipeline requesters and the arbiter.
interface wb_arbiter_if
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW
);

  logic                     stall;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic                     rf_we;
  logic [AW-1:0]            rf_addr;
  logic [DW-1:0]            rf_wd;
  logic [2**AW-1:0]         wb_pending;
  logic [15:0]              conflict_cnt;

  // Requester / pipeline side.
  modport master (
    output stall, req_valid, req_addr, req_data,
    input  req_ready, rf_we, rf_addr, rf_wd, wb_pending, conflict_cnt
  );

  // Arbiter side.
  modport slave (
    input  stall, req_valid, req_addr, req_data,
    output req_ready, rf_we, rf_addr, rf_wd, wb_pending, conflict_cnt
  );

endinterface

// File: rtl/wb_arbiter_rr_arbiter.sv
// Round-robin one-hot grant: search upward from ptr, wrapping at NREQ-1.
module rr_arbiter #(
  parameter int NREQ = 3,
  localparam int PW  = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] grant
);

  // First requesting index at or after ptr (circularly) wins.
  always_comb begin
    logic found;
    int   idx;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int k = 0; k < NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (!found && req[idx]) begin
        grant[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Write-back arbiter: shares one register-file write port among NREQ
// requesters, registers the winning write, and counts contention cycles.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int NREQ = 3,
  parameter int AW   = WB_AW,
  parameter int DW   = WB_DW
) (
  input  logic        clk,
  input  logic        rst,
  wb_arbiter_if.slave bus
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   ptr_next;
  logic [PW-1:0]   sel_idx;
  logic [NREQ-1:0] grant;
  logic [NREQ-1:0] ready;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_data;
  logic            transfer;
  logic            rf_we;
  logic [AW-1:0]   rf_addr;
  logic [DW-1:0]   rf_wd;
  logic [15:0]     conflict_cnt;

  rr_arbiter #(.NREQ(NREQ)) u_rr (
    .req   (bus.req_valid),
    .ptr   (rr_ptr),
    .grant (grant)
  );

  // Grants are withheld during reset and pipeline stall; the grant is only
  // ever non-zero for a valid requester, so any ready bit means a transfer.
  assign ready         = (rst || bus.stall) ? '0 : grant;
  assign transfer      = |ready;
  assign bus.req_ready = ready;

  // Select the granted requester's payload and compute the pointer successor.
  always_comb begin
    sel_idx  = '0;
    sel_addr = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        sel_idx  = PW'(i);
        sel_addr = bus.req_addr[i];
        sel_data = bus.req_data[i];
      end
    end
    ptr_next = (sel_idx == PW'(NREQ - 1)) ? '0 : sel_idx + 1'b1;
  end

  // Output register stage and round-robin pointer; writes to x0 are
  // accepted but dropped, and address/data only move on a real write.
  always_ff @(posedge clk) begin
    if (rst) begin
      rf_we   <= 1'b0;
      rf_addr <= '0;
      rf_wd   <= '0;
      rr_ptr  <= '0;
    end else begin
      rf_we <= transfer && (sel_addr != '0);
      if (transfer && (sel_addr != '0)) begin
        rf_addr <= sel_addr;
        rf_wd   <= sel_data;
      end
      if (transfer) begin
        rr_ptr <= ptr_next;
      end
    end
  end

  // Saturating count of cycles with two or more requests, stall or not.
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_cnt <= '0;
    end else if (($countones(bus.req_valid) >= 2) && (conflict_cnt != 16'hFFFF)) begin
      conflict_cnt <= conflict_cnt + 16'd1;
    end
  end

  // One-hot decode of the register currently being written.
  for (genvar gi = 0; gi < 2 ** AW; gi++) begin : g_pending
    assign bus.wb_pending[gi] = rf_we && (rf_addr == AW'(gi));
  end

  assign bus.rf_we        = rf_we;
  assign bus.rf_addr      = rf_addr;
  assign bus.rf_wd        = rf_wd;
  assign bus.conflict_cnt = conflict_cnt;

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: reset, fairness, single write, x0 drop,
// stall, reset mid-flight and counter saturation.
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  wb_arbiter_if #(.NREQ(3), .AW(WB_AW), .DW(WB_DW)) bus ();

  wb_arbiter #(.NREQ(3), .AW(WB_AW), .DW(WB_DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; return 1 ns after the edge so sampling is off-edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] v, input logic s);
    bus.req_valid = v;
    bus.stall     = s;
    #2;
    $display("step t=%0t valid=%b stall=%b ready=%b rf_we=%b rf_addr=%0d rf_wd=%h cnt=%0d",
             $time, v, s, bus.req_ready, bus.rf_we, bus.rf_addr, bus.rf_wd, bus.conflict_cnt);
  endtask

  wb_req_t vec [3];

  initial begin
    vec[0] = '{valid: 1'b1, addr: 5'd1, data: 32'h1111_0000};
    vec[1] = '{valid: 1'b1, addr: 5'd2, data: 32'h2222_0000};
    vec[2] = '{valid: 1'b1, addr: 5'd3, data: 32'h3333_0000};
    for (int i = 0; i < 3; i++) begin
      bus.req_addr[i] = vec[i].addr;
      bus.req_data[i] = vec[i].data;
    end
    bus.req_valid = '0;
    bus.stall     = 1'b0;

    // Reset: all valid held while in reset, no grants, state cleared.
    rst = 1'b1;
    tick();
    drive(3'b111, 1'b0);
    chk("rst_ready", bus.req_ready, 3'b000);
    tick();
    chk("rst_we", bus.rf_we, 1'b0);
    chk("rst_addr", bus.rf_addr, 5'd0);
    chk("rst_wd", bus.rf_wd, 32'd0);
    chk("rst_cnt", bus.conflict_cnt, 16'd0);
    chk("rst_ptr", dut.rr_ptr, 2'd0);
    chk("rst_pending", bus.wb_pending, 32'd0);

    // Fairness: all three held from reset -> 0,1,2,0.
    rst = 1'b0;
    drive(3'b111, 1'b0);
    chk("fair_g0", bus.req_ready, 3'b001);
    tick();
    chk("fair_we0", bus.rf_we, 1'b1);
    chk("fair_addr0", bus.rf_addr, 5'd1);
    chk("fair_wd0", bus.rf_wd, 32'h1111_0000);
    chk("fair_g1", bus.req_ready, 3'b010);
    tick();
    chk("fair_addr1", bus.rf_addr, 5'd2);
    chk("fair_g2", bus.req_ready, 3'b100);
    tick();
    chk("fair_addr2", bus.rf_addr, 5'd3);
    chk("fair_pend2", bus.wb_pending, 32'h0000_0008);
    chk("fair_g3", bus.req_ready, 3'b001);
    tick();
    chk("fair_cnt", bus.conflict_cnt, 16'd4);
    chk("fair_ptr", dut.rr_ptr, 2'd1);

    // Idle cycle: no transfer, outputs hold.
    drive(3'b000, 1'b0);
    chk("idle_ready", bus.req_ready, 3'b000);
    tick();
    chk("idle_we", bus.rf_we, 1'b0);
    chk("idle_addr", bus.rf_addr, 5'd1);
    chk("idle_wd", bus.rf_wd, 32'h1111_0000);

    // Single requester 1 writes 0xDEADBEEF to x5.
    bus.req_addr[1] = 5'd5;
    bus.req_data[1] = 32'hDEAD_BEEF;
    drive(3'b010, 1'b0);
    chk("single_ready", bus.req_ready, 3'b010);
    tick();
    drive(3'b000, 1'b0);
    chk("single_we", bus.rf_we, 1'b1);
    chk("single_addr", bus.rf_addr, 5'd5);
    chk("single_wd", bus.rf_wd, 32'hDEAD_BEEF);
    chk("single_pend", bus.wb_pending, 32'h0000_0020);
    chk("single_ptr", dut.rr_ptr, 2'd2);

    // x0 write from requester 0: accepted, dropped, pointer moves to 1.
    bus.req_addr[0] = 5'd0;
    bus.req_data[0] = 32'h1;
    drive(3'b001, 1'b0);
    chk("x0_ready", bus.req_ready, 3'b001);
    tick();
    drive(3'b000, 1'b0);
    chk("x0_we", bus.rf_we, 1'b0);
    chk("x0_pend", bus.wb_pending, 32'd0);
    chk("x0_ptr", dut.rr_ptr, 2'd1);

    // Fresh reset, then stall with requesters 0 and 2 valid for 3 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.req_addr[0] = 5'd10;
    bus.req_data[0] = 32'hA0A0_A0A0;
    bus.req_addr[2] = 5'd12;
    bus.req_data[2] = 32'hC2C2_C2C2;
    for (int c = 0; c < 3; c++) begin
      drive(3'b101, 1'b1);
      chk("stall_ready", bus.req_ready, 3'b000);
      tick();
      chk("stall_we", bus.rf_we, 1'b0);
    end
    chk("stall_cnt", bus.conflict_cnt, 16'd3);
    drive(3'b101, 1'b0);
    chk("unstall_g0", bus.req_ready, 3'b001);
    tick();
    chk("unstall_addr0", bus.rf_addr, 5'd10);
    drive(3'b100, 1'b0);
    chk("unstall_g2", bus.req_ready, 3'b100);
    tick();
    chk("unstall_we2", bus.rf_we, 1'b1);
    chk("unstall_addr2", bus.rf_addr, 5'd12);
    chk("unstall_wd2", bus.rf_wd, 32'hC2C2_C2C2);

    // Reset mid-flight: transfer to x7, then reset discards the pending state.
    bus.req_addr[1] = 5'd7;
    drive(3'b010, 1'b0);
    chk("mid_ready", bus.req_ready, 3'b010);
    tick();
    rst = 1'b1;
    drive(3'b011, 1'b0);
    chk("mid_we_visible", bus.rf_we, 1'b1);
    chk("mid_rst_ready", bus.req_ready, 3'b000);
    tick();
    chk("mid_we", bus.rf_we, 1'b0);
    chk("mid_ptr", dut.rr_ptr, 2'd0);
    rst = 1'b0;
    drive(3'b110, 1'b0);
    chk("mid_first", bus.req_ready, 3'b010);

    // Saturation: two requests held well past 65535 cycles.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    drive(3'b011, 1'b1);
    repeat (65533) tick();
    tick();
    chk("sat_fffe", bus.conflict_cnt, 16'hFFFE);
    tick();
    chk("sat_ffff", bus.conflict_cnt, 16'hFFFF);
    repeat (4465) tick();
    chk("sat_hold", bus.conflict_cnt, 16'hFFFF);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
